// File: rtl/pov_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pov_pkg: shared state encoding and default sizing for the POV      |
// | column sequencer.                          Revision: 1.0           |
// +--------------------------------------------------------------------+
package pov_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SHOW  = 2'd3
  } state_e;

  localparam int POV_NUM_COLS   = 64;
  localparam int POV_COL_HOLD   = 4;
  localparam int POV_NUM_FRAMES = 2;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pov_hold_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pov_hold_timer: loadable down-counter timing the SHOW phase of a   |
// | column, with a zero flag.                  Revision: 1.0           |
// +--------------------------------------------------------------------+
module pov_hold_timer #(
  parameter int WIDTH    = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic zero
);

  localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_V;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pov_column_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pov_column_sequencer: steps a pattern ROM column by column onto    |
// | the LED drive, NUM_FRAMES frames per run.  Revision: 1.0           |
// +--------------------------------------------------------------------+
module pov_column_sequencer
  import pov_pkg::*;
#(
  parameter int NUM_COLS   = POV_NUM_COLS,
  parameter int ADDR_W     = 6,
  parameter int COL_HOLD   = POV_COL_HOLD,
  parameter int NUM_FRAMES = POV_NUM_FRAMES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stop,
  input  logic              index,
  output logic [ADDR_W-1:0] col_addr,
  input  logic [15:0]       col_data,
  output logic [15:0]       ledsOut,
  output logic              busy,
  output logic              frame_done
);

  localparam int HOLD_W  = cnt_width(COL_HOLD - 1);
  localparam int FRAME_W = cnt_width(NUM_FRAMES);

  localparam logic [ADDR_W-1:0]  LAST_COL   = ADDR_W'(NUM_COLS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   col_addr_q, col_addr_d;
  logic [15:0]         leds_q, leds_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                run_q;

  logic start;
  logic hold_load, hold_dec, hold_clr, hold_zero;

  assign start = run & ~run_q;

  pov_hold_timer #(
    .WIDTH    (HOLD_W),
    .LOAD_VAL (COL_HOLD - 1)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .dec  (hold_dec),
    .clr  (hold_clr),
    .zero (hold_zero)
  );

  always_comb begin
    state_d      = state_q;
    col_addr_d   = col_addr_q;
    leds_d       = leds_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    hold_load    = 1'b0;
    hold_dec     = 1'b0;
    hold_clr     = 1'b0;

    if (state_q == ST_IDLE) begin
      leds_d     = '0;
      col_addr_d = '0;
      if (start && !stop) begin
        state_d     = ST_FETCH;
        frame_cnt_d = '0;
      end
    end else if (stop) begin
      state_d    = ST_IDLE;
      leds_d     = '0;
      col_addr_d = '0;
      hold_clr   = 1'b1;
    end else if (index) begin
      // Rotor resync restarts the frame but keeps the frame count.
      state_d    = ST_FETCH;
      col_addr_d = '0;
      hold_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          leds_d    = col_data;
          hold_load = 1'b1;
          state_d   = ST_SHOW;
        end
        ST_SHOW: begin
          if (!hold_zero) begin
            hold_dec = 1'b1;
          end else if (col_addr_q != LAST_COL) begin
            col_addr_d = col_addr_q + 1'b1;
            state_d    = ST_FETCH;
          end else begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 1'b1;
            col_addr_d   = '0;
            if (frame_cnt_q == LAST_FRAME) begin
              state_d = ST_IDLE;
              leds_d  = '0;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_addr_q   <= '0;
      leds_q       <= '0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_addr_q   <= col_addr_d;
      leds_q       <= leds_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      run_q        <= run;
    end
  end

  assign col_addr   = col_addr_q;
  assign ledsOut    = leds_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pov_column_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pov_column_sequencer: scoreboard bench with a frame-timeline    |
// | reference model.                           Revision: 1.0           |
// +--------------------------------------------------------------------+
module tb_pov_column_sequencer;

  localparam int NC = 4;
  localparam int AW = 2;
  localparam int H  = 3;
  localparam int NF = 2;
  localparam int P  = H + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          stop;
  logic          index;
  logic [AW-1:0] col_addr;
  logic [15:0]   col_data;
  logic [15:0]   leds_out;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  pov_column_sequencer #(
    .NUM_COLS   (NC),
    .ADDR_W     (AW),
    .COL_HOLD   (H),
    .NUM_FRAMES (NF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .stop       (stop),
    .index      (index),
    .col_addr   (col_addr),
    .col_data   (col_data),
    .ledsOut    (leds_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Pattern ROM with one cycle of read latency.
  always_ff @(posedge clk) col_data <= 16'h0001 << col_addr;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   leds;
    logic          busy;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Reference model: position within the current frame as a cycle offset t,
  // where each column occupies P cycles (FETCH, LOAD, then H SHOW cycles).
  bit          m_active;
  int          m_t;
  int          m_frames;
  logic [15:0] m_leds;
  bit          m_run_prev;

  function automatic logic [15:0] rom(input int col);
    logic [15:0] one;
    one = 16'h0001;
    return one << col;
  endfunction

  task automatic model_reset();
    m_active   = 1'b0;
    m_t        = 0;
    m_frames   = 0;
    m_leds     = '0;
    m_run_prev = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit ix, output exp_t e);
    bit start;
    start      = r && !m_run_prev;
    m_run_prev = r;
    e.fd       = 1'b0;
    if (!m_active) begin
      if (start && !s) begin
        m_active = 1'b1;
        m_t      = 0;
        m_frames = 0;
      end
    end else if (s) begin
      m_active = 1'b0;
      m_leds   = '0;
    end else if (ix) begin
      m_t = 0;
    end else begin
      if (m_t % P == 1) m_leds = rom(m_t / P);
      m_t++;
      if (m_t == NC * P) begin
        e.fd = 1'b1;
        m_frames++;
        m_t = 0;
        if (m_frames == NF) begin
          m_active = 1'b0;
          m_leds   = '0;
        end
      end
    end
    e.busy = m_active;
    e.addr = m_active ? AW'(m_t / P) : '0;
    e.leds = m_leds;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock: advance model at the edge, queue its expectation, then let
  // the caller drive the next inputs.
  task automatic step();
    exp_t e;
    @(posedge clk);
    if (rst) begin
      model_reset();
      e = '0;
    end else begin
      model_edge(run, stop, index, e);
    end
    exp_q.push_back(e);
    mon_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (col_addr !== mon_e.addr || leds_out !== mon_e.leds ||
            busy !== mon_e.busy || frame_done !== mon_e.fd) begin
          errors++;
          $display("FAIL outputs @%0t: got addr=%0d leds=%h busy=%b fd=%b expected addr=%0d leds=%h busy=%b fd=%b",
                   $time, col_addr, leds_out, busy, frame_done,
                   mon_e.addr, mon_e.leds, mon_e.busy, mon_e.fd);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit index_done, stop_done;
    rst   = 1'b1;
    run   = 1'b0;
    stop  = 1'b0;
    index = 1'b0;
    model_reset();
    index_done = 1'b0;
    stop_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_col_addr", 32'(col_addr), 32'd0);
    check("reset_leds", 32'(leds_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Directed scenarios, then randomized traffic.
    for (int c = 0; c < 3200; c++) begin
      step();
      index = 1'b0;
      stop  = 1'b0;
      if (c < 200) begin
        case (c)
          0:   run = 1'b1;
          10:  run = 1'b0;
          12:  run = 1'b1;
          60:  run = 1'b0;
          62:  begin run = 1'b1; stop = 1'b1; end
          65:  run = 1'b0;
          67:  run = 1'b1;
          140: run = 1'b0;
          142: run = 1'b1;
          180: run = 1'b0;
          default: ;
        endcase
        if (c >= 70 && c < 110 && !index_done && leds_out == 16'h0004) begin
          index      = 1'b1;
          index_done = 1'b1;
        end
        if (c >= 144 && c < 175 && !stop_done && leds_out == 16'h0004) begin
          stop      = 1'b1;
          stop_done = 1'b1;
        end
      end else begin
        if ($urandom_range(0, 19) == 0) run = ~run;
        stop  = ($urandom_range(0, 149) == 0);
        index = ($urandom_range(0, 89) == 0);
      end
    end

    // Asynchronous reset while a column is on display.
    stop = 1'b1;
    step();
    stop = 1'b0;
    run  = 1'b0;
    step();
    step();
    run = 1'b1;
    repeat (5) step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_leds", 32'(leds_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_col_addr", 32'(col_addr), 32'd0);
    check("async_rst_frame_done", 32'(frame_done), 32'd0);
    step();
    rst = 1'b0;
    repeat (12) step();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
